load_store_unit: RTL

- Sits directly downstream of the core's data-memory port. Converts the core's per-instruction load/store controls into a valid/ready request plus response transaction on the data bus.
- Stalls the core while the access is outstanding.
- Handles byte-lane steering, write strobes, and load sign/zero extension.
- Reports misaligned, illegal-width and bus-timeout faults.

---
 rtl/load_store_unit.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: bridges core load/store controls onto a valid/ready data bus.
// Handles lane steering, write strobes, load extension and access faults.
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read_control,
    input  logic                  mem_write_control,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_data_in,
    output logic [31:0]           mem_data_out,
    output logic                  stall,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_rsp_valid,
    input  logic [31:0]           bus_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RSP,
        DONE,
        FAULT
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TO_EN = (TIMEOUT > 0);

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_MISAL = 2'b01;
    localparam logic [1:0] C_ILL   = 2'b10;
    localparam logic [1:0] C_TO    = 2'b11;

    state_t state, nxt;

    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic [1:0]            cause_q, nxt_cause;
    logic [31:0]           data_q;

    logic        acc, illegal, misal, to_hit;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] lane, ld_data;

    assign acc = mem_read_control | mem_write_control;

    assign illegal =
        (mem_read_control & mem_write_control) |
        (mem_read_control & (funct3 == 3'b011 || funct3 == 3'b110 ||
                             funct3 == 3'b111)) |
        (mem_write_control & (funct3 == 3'b011 || funct3[2]));

    assign misal =
        (funct3[1:0] == 2'b01 && mem_address[0]) ||
        (funct3[1:0] == 2'b10 && mem_address[1:0] != 2'b00);

    assign to_hit = TO_EN && (cnt == TO_LIM);

    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        if (mem_write_control) begin
            unique case (funct3[1:0])
                2'b00: begin
                    st_wdata = {4{mem_data_in[7:0]}};
                    st_wstrb = 4'b0001 << mem_address[1:0];
                end
                2'b01: begin
                    st_wdata = {2{mem_data_in[15:0]}};
                    st_wstrb = 4'b0011 << {mem_address[1], 1'b0};
                end
                default: begin
                    st_wdata = mem_data_in;
                    st_wstrb = 4'b1111;
                end
            endcase
        end
    end

    assign lane = bus_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_data = bus_rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ld_data = {24'd0, lane[7:0]};
            3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ld_data = {16'd0, lane[15:0]};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        nxt       = state;
        nxt_cause = cause_q;
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    !acc: ;
                    acc && illegal: begin
                        nxt       = FAULT;
                        nxt_cause = C_ILL;
                    end
                    acc && !illegal && misal: begin
                        nxt       = FAULT;
                        nxt_cause = C_MISAL;
                    end
                    acc && !illegal && !misal: nxt = REQ;
                endcase
            end
            REQ: begin
                if (bus_req_ready) begin
                    nxt = WAIT_RSP;
                end else if (to_hit) begin
                    nxt       = FAULT;
                    nxt_cause = C_TO;
                end
            end
            WAIT_RSP: begin
                if (bus_rsp_valid) begin
                    nxt = DONE;
                end else if (to_hit) begin
                    nxt       = FAULT;
                    nxt_cause = C_TO;
                end
            end
            DONE:    nxt = IDLE;
            FAULT:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cause_q <= C_NONE;
            data_q  <= '0;
        end else begin
            state   <= nxt;
            cause_q <= nxt_cause;
            if (state == IDLE && nxt == REQ) begin
                addr_q  <= mem_address;
                we_q    <= mem_write_control;
                f3_q    <= funct3;
                wdata_q <= st_wdata;
                wstrb_q <= st_wstrb;
                cnt     <= '0;
            end else if ((state == REQ || state == WAIT_RSP) &&
                         cnt != TO_LIM) begin
                cnt <= cnt + CW'(1);
            end
            // Stores complete with a zero result; faults also zero it.
            if (state == WAIT_RSP && bus_rsp_valid) begin
                data_q <= we_q ? 32'd0 : ld_data;
            end else if (nxt == FAULT) begin
                data_q <= '0;
            end
        end
    end

    assign stall = reset & ((state == IDLE && acc) ||
                            state == REQ || state == WAIT_RSP);

    assign fault         = (state == FAULT);
    assign fault_cause   = (state == FAULT) ? cause_q : C_NONE;
    assign bus_req_valid = (state == REQ);
    assign bus_we        = we_q;
    assign bus_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_wdata     = wdata_q;
    assign bus_wstrb     = wstrb_q;
    assign mem_data_out  = data_q;

endmodule
